agendador_tiro_inimigo: RTL
===========================

# agendador_tiro_inimigo

Selects which live invader fires next and issues the enemy-shot request consumed by the enemy-bullet path (`ID_enemy_tiro` drives the enemy-shot origin lookup feeding `municao2`). Upstream of the top-level shot origin logic. A cooldown timer paces shots. A free-running LFSR picks a column, and the bottom-most live invader in that column fires. Columns are the 8 positions per row; there are 3 rows, and index = row*8 + column.

## Interface
Parameters:
- `COOLDOWN`, default 50_000_000: clock cycles spent in WAIT between shot attempts. Minimum 1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- `clk`: input, 1 bit. System clock.
- `reset`: input, 1 bit. Asynchronous, active-low. 0 resets the block.
- `jogo_ativo`: input, 1 bit. 1 while the game is in the playing state.
- `enemy_vivos`: input, 24 bits. Alive mask; bit i corresponds to invader i.
- `tiro_livre`: input, 1 bit. 1 when the enemy bullet is inactive and may be relaunched.
- `ID_enemy_tiro`: output, 6 bits. Index (0..23) of the invader that fired. Held between shots.
- `disparo`: output, 1 bit. One-cycle pulse; launch bullet from `ID_enemy_tiro`.
- `lfsr_out`: output, 16 bits. Current LFSR state, exported for other random uses.

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clock while reset is not asserted, regardless of state.
- States: IDLE, WAIT, PICK, SCAN, FIRE.
- IDLE: outputs held. When `jogo_ativo`=1, go to WAIT and load counter = COOLDOWN-1.
- WAIT: counter decrements each cycle. At counter==0, go to PICK.
- PICK: col <= `lfsr_out[2:0]`, tries <= 0. Go to SCAN.
- SCAN (one column per cycle):
  - If bit 16+col is alive, target = 16+col. Otherwise, if bit 8+col is alive, target = 8+col. Otherwise, if bit col is alive, target = col.
  - When a target is found, go to FIRE.
  - If no bit in the column is alive: col <= (col+1) mod 8 and tries <= tries+1. When tries reaches 7 with no hit (8 columns checked), go to WAIT and reload the counter. No shot is fired.
- FIRE:
  - If the target is no longer alive, return to PICK.
  - Otherwise, if `tiro_livre`=1: `ID_enemy_tiro` <= target, `disparo` <= 1, go to WAIT and reload the counter.
  - Otherwise, stay in FIRE.
- `disparo` is registered and high for exactly one cycle; it is 0 in every other cycle.
- Any state except IDLE: `jogo_ativo`=0 causes a transition to IDLE on the next edge. No pulse is issued on that edge, and `ID_enemy_tiro` keeps its value.
- When `enemy_vivos`=0, SCAN always exhausts its columns and no shot is ever issued.

## Timing
- Reset (asynchronous, immediate) sets:
  - `ID_enemy_tiro`=0, `disparo`=0
  - LFSR = LFSR_SEED (or 1 if the seed is 0), so `lfsr_out` shows that value
  - state IDLE, counter 0, col 0, tries 0
- Release of reset is sampled on the next rising edge.
- Best-case latency: `disparo` is high in the cycle following edge N+COOLDOWN+3, where edge N is the first edge that samples `jogo_ativo`=1. The path is IDLE→WAIT (N), COOLDOWN cycles of WAIT, then PICK, SCAN hit, and FIRE with `tiro_livre`=1.
- Each empty column examined adds 1 cycle; the worst case is 8 SCAN cycles.
- Each FIRE cycle with `tiro_livre`=0 adds 1 cycle. There is no timeout.
- Minimum spacing between two `disparo` pulses is COOLDOWN+3 cycles.
- `enemy_vivos` and `tiro_livre` are sampled synchronously each cycle and are not registered internally.

## Test plan
- Reset: hold `reset`=0 while clocking. Required: `disparo`=0, `ID_enemy_tiro`=0, `lfsr_out`=16'hACE1. With LFSR_SEED=0, `lfsr_out`=1.
- Best case (COOLDOWN=4, all 24 invaders alive, `tiro_livre`=1, `jogo_ativo` rises at edge 0): single `disparo` pulse after edge 7. `ID_enemy_tiro` = 16 + (`lfsr_out[2:0]` captured in PICK).
- Empty-column skip: `enemy_vivos` = only bit 5 set (column 5, row 0), and PICK sees column 6. Required: SCAN visits columns 6, 7, 0 … 5 (8 cycles), then fires with `ID_enemy_tiro`=5.
- Bullet busy, then target dies: `tiro_livre`=0 in FIRE for 10 cycles, no pulse. Clear the target's alive bit: the block returns to PICK. Set `tiro_livre`=1: the pulse carries a still-live index.
- All dead: `enemy_vivos`=0 for 1000 cycles. Required: `disparo` never high; the block cycles WAIT→PICK→SCAN(8)→WAIT.
- Mid-operation abort: drop `jogo_ativo` during FIRE, or assert reset during SCAN. Required: no pulse. The block returns to IDLE (`ID_enemy_tiro` held), or, for reset, all outputs immediately take their reset values.

Source files
------------

// File: rtl/agendador_tiro_inimigo_if.sv
// Shot-scheduler bus: game-state inputs in, enemy-shot request out.
// The master side is the scheduler, which issues the request.
interface agendador_tiro_inimigo_if;
  logic        jogo_ativo;
  logic [23:0] enemy_vivos;
  logic        tiro_livre;
  logic [5:0]  ID_enemy_tiro;
  logic        disparo;
  logic [15:0] lfsr_out;

  modport master (
    input  jogo_ativo, enemy_vivos, tiro_livre,
    output ID_enemy_tiro, disparo, lfsr_out
  );
  modport slave (
    output jogo_ativo, enemy_vivos, tiro_livre,
    input  ID_enemy_tiro, disparo, lfsr_out
  );
endinterface

// File: rtl/agendador_tiro_inimigo.sv
// Enemy shot scheduler: a cooldown paces attempts, an LFSR picks a column,
// and the bottom-most live invader in that column fires.
module agendador_tiro_inimigo #(
  parameter int unsigned COOLDOWN  = 50_000_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                       clk,
  input logic                       reset,
  agendador_tiro_inimigo_if.master  bus
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN - 1);

  typedef enum logic [2:0] {IDLE, WAIT, PICK, SCAN, FIRE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      col, col_n, tries, tries_n;
  logic [4:0]      target, target_n;
  logic [5:0]      id_q, id_n;
  logic            disparo_q, disparo_n;
  logic [15:0]     lfsr;
  logic [2:0][7:0] rows;

  // Row view of the alive mask: rows[2] is the bottom row (indices 16..23).
  assign rows = bus.enemy_vivos;

  assign bus.ID_enemy_tiro = id_q;
  assign bus.disparo       = disparo_q;
  assign bus.lfsr_out      = lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; runs in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      col       <= '0;
      tries     <= '0;
      target    <= '0;
      id_q      <= '0;
      disparo_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      col       <= col_n;
      tries     <= tries_n;
      target    <= target_n;
      id_q      <= id_n;
      disparo_q <= disparo_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    col_n     = col;
    tries_n   = tries;
    target_n  = target;
    id_n      = id_q;
    disparo_n = 1'b0;
    // Leaving the playing state overrides everything, including a pending shot.
    if (state != IDLE && !bus.jogo_ativo) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.jogo_ativo) begin
          state_n = WAIT;
          cnt_n   = CNT_LOAD;
        end
        WAIT: begin
          if (cnt == '0) state_n = PICK;
          else           cnt_n   = cnt - CW'(1);
        end
        PICK: begin
          col_n   = lfsr[2:0];
          tries_n = '0;
          state_n = SCAN;
        end
        SCAN: begin
          if (rows[2][col]) begin
            target_n = {2'b10, col};
            state_n  = FIRE;
          end else if (rows[1][col]) begin
            target_n = {2'b01, col};
            state_n  = FIRE;
          end else if (rows[0][col]) begin
            target_n = {2'b00, col};
            state_n  = FIRE;
          end else begin
            col_n   = col + 3'd1;
            tries_n = tries + 3'd1;
            if (tries == 3'd7) begin
              state_n = WAIT;
              cnt_n   = CNT_LOAD;
            end
          end
        end
        FIRE: begin
          if (!bus.enemy_vivos[target]) begin
            state_n = PICK;
          end else if (bus.tiro_livre) begin
            id_n      = {1'b0, target};
            disparo_n = 1'b1;
            state_n   = WAIT;
            cnt_n     = CNT_LOAD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
